// File: rtl/fruit_drop_engine.sv
// fruit_drop_engine: game-object engine for the farmer-catch game.
// Owns the farmer lane, four falling objects (bug, green, orange, yellow),
// staggered spawning from an LFSR, collision against the farmer and both
// saturating score counters. Every output comes straight from a register.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   clear      one-cycle pulse, same effect as rst
//   game_en    1 = game running, 0 = freeze all state
//   game_tick  one-cycle pulse, advances object motion
//   key_left   one-cycle pulse, farmer one lane left
//   key_right  one-cycle pulse, farmer one lane right
//   farmer_x   farmer lane
//   obj_x      object lanes {yellow,orange,green,bug}, 3 b each
//   obj_y      object top rows {yellow,orange,green,bug}, 10 b each
//   obj_active per-object visible flag, same order
//   score_pos  accumulated positive score
//   score_neg  accumulated penalty
//   catch_evt  one-cycle pulse per object caught
module fruit_drop_engine #(
  parameter int unsigned LANES     = 8,
  parameter int unsigned TILE      = 80,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned FARMER_Y  = 400,
  parameter int unsigned STEP      = 4,
  parameter int unsigned RESPAWN   = 20,
  parameter int unsigned SCORE_MAX = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        game_en,
  input  logic        game_tick,
  input  logic        key_left,
  input  logic        key_right,
  output logic [2:0]  farmer_x,
  output logic [11:0] obj_x,
  output logic [39:0] obj_y,
  output logic [3:0]  obj_active,
  output logic [5:0]  score_pos,
  output logic [5:0]  score_neg,
  output logic [3:0]  catch_evt
);

  // Counters must hold both RESPAWN and the largest staggered reset value (13).
  localparam int unsigned CntMax = (RESPAWN > 13) ? RESPAWN : 13;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  logic [2:0]           farmer_q, farmer_d;
  logic [3:0][2:0]      x_q, x_d;
  logic [3:0][9:0]      y_q, y_d;
  logic [3:0]           act_q, act_d;
  logic [3:0][CW-1:0]   cnt_q, cnt_d;
  logic [5:0]           pos_q, pos_d;
  logic [5:0]           neg_q, neg_d;
  logic [3:0]           evt_q, evt_d;
  logic [15:0]          lfsr_q, lfsr_d;

  logic [2:0]           spawn_x;
  logic                 spawn_taken;
  logic [3:0]           add_pos, add_neg;
  logic [10:0]          ny;
  logic [CW-1:0]        cnt_dec;
  logic [6:0]           pos_sum, neg_sum;

  assign spawn_x = 3'(32'(lfsr_q[2:0]) % LANES);

  always_comb begin
    farmer_d    = farmer_q;
    x_d         = x_q;
    y_d         = y_q;
    act_d       = act_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    neg_d       = neg_q;
    evt_d       = '0;
    lfsr_d      = lfsr_q;
    spawn_taken = 1'b0;
    add_pos     = '0;
    add_neg     = '0;
    ny          = '0;
    cnt_dec     = '0;
    pos_sum     = '0;
    neg_sum     = '0;

    if (game_en) begin
      if (key_left && !key_right && farmer_q != 3'd0) begin
        farmer_d = farmer_q - 3'd1;
      end else if (key_right && !key_left && 32'(farmer_q) < LANES - 1) begin
        farmer_d = farmer_q + 3'd1;
      end

      if (game_tick) begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        // Collision uses farmer_q so a same-cycle key press does not affect it.
        for (int i = 0; i < 4; i++) begin
          if (!act_q[i]) begin
            cnt_dec  = (cnt_q[i] == '0) ? '0 : cnt_q[i] - CW'(1);
            cnt_d[i] = cnt_dec;
            // Lowest index wins; a blocked object waits with its counter at 0.
            if (cnt_dec == '0 && !spawn_taken) begin
              spawn_taken = 1'b1;
              act_d[i]    = 1'b1;
              y_d[i]      = '0;
              x_d[i]      = spawn_x;
            end
          end else begin
            ny = 11'(y_q[i]) + ((i == 3) ? 11'(2 * STEP) : 11'(STEP));
            if (ny >= 11'(FARMER_Y - TILE) && x_q[i] == farmer_q) begin
              act_d[i] = 1'b0;
              evt_d[i] = 1'b1;
              cnt_d[i] = CW'(RESPAWN);
              if (i == 0) add_neg = add_neg + 4'd3;
              else        add_pos = add_pos + 4'(i);
            end else if (ny >= 11'(SCREEN_H)) begin
              act_d[i] = 1'b0;
              cnt_d[i] = CW'(RESPAWN);
              if (i != 0) add_neg = add_neg + 4'd1;
            end else begin
              y_d[i] = ny[9:0];
            end
          end
        end

        pos_sum = 7'(pos_q) + 7'(add_pos);
        neg_sum = 7'(neg_q) + 7'(add_neg);
        pos_d   = (pos_sum > 7'(SCORE_MAX)) ? 6'(SCORE_MAX) : pos_sum[5:0];
        neg_d   = (neg_sum > 7'(SCORE_MAX)) ? 6'(SCORE_MAX) : neg_sum[5:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      farmer_q <= 3'd3;
      act_q    <= '0;
      evt_q    <= '0;
      pos_q    <= '0;
      neg_q    <= '0;
      lfsr_q   <= 16'hACE1;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= 3'(2 * i);
        y_q[i]   <= '0;
        cnt_q[i] <= CW'(4 * i + 1);
      end
    end else begin
      farmer_q <= farmer_d;
      x_q      <= x_d;
      y_q      <= y_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      evt_q    <= evt_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign farmer_x   = farmer_q;
  assign obj_x      = x_q;
  assign obj_y      = y_q;
  assign obj_active = act_q;
  assign score_pos  = pos_q;
  assign score_neg  = neg_q;
  assign catch_evt  = evt_q;

endmodule

// File: tb/tb_fruit_drop_engine.sv
// Self-checking bench for fruit_drop_engine: a behavioural game model
// predicts every output each cycle (scoreboard queue), and scenario tasks
// add directed checks against fixed values.
module tb_fruit_drop_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        game_en = 1'b0;
  logic        game_tick = 1'b0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic [2:0]  farmer_x;
  logic [11:0] obj_x;
  logic [39:0] obj_y;
  logic [3:0]  obj_active;
  logic [5:0]  score_pos;
  logic [5:0]  score_neg;
  logic [3:0]  catch_evt;

  fruit_drop_engine dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .game_en    (game_en),
    .game_tick  (game_tick),
    .key_left   (key_left),
    .key_right  (key_right),
    .farmer_x   (farmer_x),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_active (obj_active),
    .score_pos  (score_pos),
    .score_neg  (score_neg),
    .catch_evt  (catch_evt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int        m_farmer;
  int        m_x   [4];
  int        m_y   [4];
  bit        m_act [4];
  int        m_cnt [4];
  int        m_pos;
  int        m_neg;
  bit [3:0]  m_evt;
  bit [15:0] m_lfsr;

  typedef struct packed {
    logic [2:0]  fx;
    logic [11:0] ox;
    logic [39:0] oy;
    logic [3:0]  act;
    logic [5:0]  sp;
    logic [5:0]  sn;
    logic [3:0]  ev;
  } snap_t;

  snap_t sb[$];
  snap_t mon_got, mon_want;

  task automatic model_reset();
    m_farmer = 3;
    for (int i = 0; i < 4; i++) begin
      m_x[i]   = 2 * i;
      m_y[i]   = 0;
      m_act[i] = 1'b0;
      m_cnt[i] = 4 * i + 1;
    end
    m_pos  = 0;
    m_neg  = 0;
    m_evt  = '0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input bit r, input bit c, input bit en, input bit tk,
                            input bit kl, input bit kr);
    int  old_f;
    int  ny;
    int  add_p;
    int  add_n;
    bit  spawned;
    if (r || c) begin
      model_reset();
      return;
    end
    m_evt = '0;
    if (!en) return;
    old_f = m_farmer;
    if (kl && !kr && m_farmer > 0) m_farmer = m_farmer - 1;
    if (kr && !kl && m_farmer < 7) m_farmer = m_farmer + 1;
    if (!tk) return;
    spawned = 1'b0;
    add_p = 0;
    add_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m_act[i]) begin
        if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0 && !spawned) begin
          spawned  = 1'b1;
          m_act[i] = 1'b1;
          m_y[i]   = 0;
          m_x[i]   = int'(m_lfsr & 16'h0007);
        end
      end else begin
        ny = m_y[i] + ((i == 3) ? 8 : 4);
        if (ny >= 320 && m_x[i] == old_f) begin
          m_act[i] = 1'b0;
          m_evt[i] = 1'b1;
          m_cnt[i] = 20;
          if (i == 0) add_n = add_n + 3;
          else        add_p = add_p + i;   // green 1, orange 2, yellow 3
        end else if (ny >= 480) begin
          m_act[i] = 1'b0;
          m_cnt[i] = 20;
          if (i != 0) add_n = add_n + 1;
        end else begin
          m_y[i] = ny;
        end
      end
    end
    m_pos = (m_pos + add_p > 63) ? 63 : m_pos + add_p;
    m_neg = (m_neg + add_n > 63) ? 63 : m_neg + add_n;
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else           m_lfsr = m_lfsr >> 1;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.fx = 3'(m_farmer);
    s.ox = '0;
    s.oy = '0;
    s.act = '0;
    for (int i = 0; i < 4; i++) begin
      s.ox[i*3 +: 3]  = 3'(m_x[i]);
      s.oy[i*10 +: 10] = 10'(m_y[i]);
      s.act[i]        = m_act[i];
    end
    s.sp = 6'(m_pos);
    s.sn = 6'(m_neg);
    s.ev = m_evt;
    return s;
  endfunction

  // Scoreboard consumer: each posedge retires the prediction pushed for it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_want = sb.pop_front();
      mon_got  = {farmer_x, obj_x, obj_y, obj_active, score_pos, score_neg, catch_evt};
      n_tests++;
      if (mon_got !== mon_want) begin
        n_fail++;
        $display("FAIL scoreboard @%0t got fx=%0d ox=%h oy=%h act=%b sp=%0d sn=%0d ev=%b want fx=%0d ox=%h oy=%h act=%b sp=%0d sn=%0d ev=%b",
                 $time, mon_got.fx, mon_got.ox, mon_got.oy, mon_got.act, mon_got.sp,
                 mon_got.sn, mon_got.ev, mon_want.fx, mon_want.ox, mon_want.oy,
                 mon_want.act, mon_want.sp, mon_want.sn, mon_want.ev);
      end
    end
  end

  task automatic cycle(input bit r, input bit c, input bit en, input bit tk,
                       input bit kl, input bit kr);
    @(negedge clk);
    rst       = r;
    clear     = c;
    game_en   = en;
    game_tick = tk;
    key_left  = kl;
    key_right = kr;
    model_step(r, c, en, tk, kl, kr);
    sb.push_back(model_snap());
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic move_to(input int lane);
    for (int k = 0; k < 8 && m_farmer != lane; k++) begin
      if (m_farmer > lane) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      else                 cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (farmer_x !== 3'd3) begin
      n_fail++; $display("FAIL reset_farmer got %0d want 3", farmer_x);
    end
    n_tests++;
    if (obj_active !== 4'b0000) begin
      n_fail++; $display("FAIL reset_active got %b want 0000", obj_active);
    end
    n_tests++;
    if (obj_x !== 12'b110_100_010_000) begin
      n_fail++; $display("FAIL reset_obj_x got %b want 110100010000", obj_x);
    end
    n_tests++;
    if (obj_y !== 40'd0) begin
      n_fail++; $display("FAIL reset_obj_y got %h want 0", obj_y);
    end
    n_tests++;
    if (score_pos !== 6'd0 || score_neg !== 6'd0 || catch_evt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_scores got pos=%0d neg=%0d evt=%b want 0 0 0000",
               score_pos, score_neg, catch_evt);
    end
  endtask

  task automatic test_farmer();
    int exp_l [5] = '{2, 1, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (farmer_x !== 3'(exp_l[k])) begin
        n_fail++; $display("FAIL farmer_left[%0d] got %0d want %0d", k, farmer_x, exp_l[k]);
      end
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (farmer_x !== 3'd4) begin
      n_fail++; $display("FAIL farmer_right got %0d want 4", farmer_x);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (farmer_x !== 3'd4) begin
      n_fail++; $display("FAIL farmer_both got %0d want 4", farmer_x);
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (farmer_x !== 3'd7) begin
      n_fail++; $display("FAIL farmer_right_edge got %0d want 7", farmer_x);
    end
  endtask

  task automatic test_green_catch();
    int budget;
    int lane;
    int pos_before;
    int want;
    bit seen;
    budget = 0;
    while (!m_act[1] && budget < 50) begin
      tick();
      budget++;
    end
    n_tests++;
    if (obj_active[1] !== 1'b1) begin
      n_fail++; $display("FAIL green_spawn got %b want 1", obj_active[1]);
    end
    lane = m_x[1];
    move_to(lane);
    n_tests++;
    if (farmer_x !== 3'(lane)) begin
      n_fail++; $display("FAIL green_farmer_lane got %0d want %0d", farmer_x, lane);
    end
    seen = 1'b0;
    budget = 0;
    pos_before = m_pos;
    while (!seen && budget < 120) begin
      pos_before = m_pos;
      tick();
      budget++;
      if (catch_evt[1] === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL green_catch_evt got 0 want 1 within 120 ticks");
    end
    want = pos_before + 1 + (m_evt[2] ? 2 : 0) + (m_evt[3] ? 3 : 0);
    if (want > 63) want = 63;
    n_tests++;
    if (score_pos !== 6'(want)) begin
      n_fail++; $display("FAIL green_score got %0d want %0d", score_pos, want);
    end
    n_tests++;
    if (obj_active[1] !== 1'b0) begin
      n_fail++; $display("FAIL green_inactive got %b want 0", obj_active[1]);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (catch_evt !== 4'b0000) begin
      n_fail++; $display("FAIL green_evt_pulse got %b want 0000", catch_evt);
    end
    for (int k = 0; k < 19; k++) tick();
    n_tests++;
    if (obj_active[1] !== 1'b0) begin
      n_fail++; $display("FAIL green_respawn_early got %b want 0", obj_active[1]);
    end
    tick();
    n_tests++;
    if (obj_active[1] !== m_act[1]) begin
      n_fail++; $display("FAIL green_respawn got %b want %b", obj_active[1], m_act[1]);
    end
  endtask

  task automatic test_orange_miss();
    int budget;
    budget = 0;
    while (m_act[2] && budget < 400) begin
      tick();
      budget++;
    end
    while (!m_act[2] && budget < 400) begin
      tick();
      budget++;
    end
    move_to((m_x[2] + 4) % 8);
    for (int k = 1; k < 120; k++) begin
      tick();
      n_tests++;
      if (obj_y[29:20] !== 10'(4 * k) || obj_active[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL orange_fall[%0d] got y=%0d act=%b want y=%0d act=1",
                 k, obj_y[29:20], obj_active[2], 4 * k);
      end
    end
    tick();
    n_tests++;
    if (obj_active[2] !== 1'b0 || catch_evt[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL orange_miss got act=%b evt=%b want act=0 evt=0",
               obj_active[2], catch_evt[2]);
    end
  endtask

  task automatic test_yellow_sat();
    int budget;
    int caught;
    budget = 0;
    caught = 0;
    while (m_pos < 63 && budget < 8000) begin
      if (m_act[3] && m_farmer != m_x[3]) move_to(m_x[3]);
      else tick();
      budget++;
    end
    n_tests++;
    if (score_pos !== 6'd63) begin
      n_fail++; $display("FAIL yellow_saturate got %0d want 63", score_pos);
    end
    while (caught < 2 && budget < 9000) begin
      if (m_act[3] && m_farmer != m_x[3]) begin
        move_to(m_x[3]);
      end else begin
        tick();
        if (catch_evt[3] === 1'b1) begin
          caught++;
          n_tests++;
          if (score_pos !== 6'd63) begin
            n_fail++; $display("FAIL yellow_hold got %0d want 63", score_pos);
          end
        end
      end
      budget++;
    end
    n_tests++;
    if (caught != 2) begin
      n_fail++; $display("FAIL yellow_post_catches got %0d want 2 within budget", caught);
    end
  endtask

  task automatic test_freeze();
    snap_t want;
    snap_t got;
    for (int k = 0; k < 30; k++) tick();
    want = model_snap();
    want.ev = '0;
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, k[0], ~k[0]);
      got = {farmer_x, obj_x, obj_y, obj_active, score_pos, score_neg, catch_evt};
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL freeze[%0d] got %h want %h", k, got, want);
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (farmer_x !== 3'd3 || obj_active !== 4'd0 || obj_x !== 12'b110_100_010_000 ||
        obj_y !== 40'd0 || score_pos !== 6'd0 || score_neg !== 6'd0 || catch_evt !== 4'd0) begin
      n_fail++;
      $display("FAIL clear got fx=%0d act=%b ox=%b sp=%0d sn=%0d want fx=3 act=0000 ox=110100010000 sp=0 sn=0",
               farmer_x, obj_active, obj_x, score_pos, score_neg);
    end
  endtask

  task automatic test_back_to_back();
    bit en, tk, kl, kr, c;
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 7) != 0);
      tk = ($urandom_range(0, 1) == 1);
      kl = ($urandom_range(0, 3) == 0);
      kr = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 299) == 0);
      cycle(1'b0, c, en, tk, kl, kr);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_farmer();
    test_green_catch();
    test_orange_miss();
    test_yellow_sat();
    test_freeze();
    test_back_to_back();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
